// File: rtl/data_mem_wait.sv
// data_mem_wait: byte-addressed data memory with a fixed multi-cycle access latency.
//
// A request is accepted in IDLE, counted down in BUSY for LATENCY cycles and
// completed with a one-cycle 'state' pulse in DONE. Write has priority over read
// when both are requested together. Addresses are aligned down to a word boundary
// and wrap modulo DEPTH. Storage (mem_array) is little-endian bytes, is never
// cleared by reset, and can be preloaded from a hex image.
//
// Optional feature: define DMEM_BYTE_STROBE_EN to add the per-byte write enable 'be'.
//
// Ports:
//   clk      - clock, rising edge
//   rst      - synchronous active-high reset
//   MemRead  - read request
//   MemWrite - write request (wins over MemRead)
//   wd       - write data
//   addr     - byte address
//   be       - byte enables, be[0] = lowest address (DMEM_BYTE_STROBE_EN only)
//   rd       - read data, held until the next read completes
//   state    - one-cycle completion pulse
module data_mem_wait #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DEPTH   = 1024,
   parameter int unsigned LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [DATA_W-1:0] wd,
   input  logic [ADDR_W-1:0] addr,
`ifdef DMEM_BYTE_STROBE_EN
   input  logic [DATA_W/8-1:0] be,
`endif
   output logic [DATA_W-1:0] rd,
   output logic              state
);

   localparam int unsigned NB   = DATA_W / 8;
   localparam int unsigned IdxW = $clog2(DEPTH);
   localparam int unsigned CntW = $clog2(LATENCY + 1);
   localparam logic [IdxW-1:0] AlignMask = ~IdxW'(NB - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   logic [7:0] mem_array [0:DEPTH-1];

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [IdxW-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0] wd_q, wd_d;
   logic [NB-1:0]     be_q, be_d;
   logic              wr_q, wr_d;
   logic [DATA_W-1:0] rd_q, rd_d;
   logic [DATA_W-1:0] rd_word;
   logic              accept;
   logic              finish;
   logic              unused_addr;

   // Upper address bits fall away in the modulo-DEPTH wrap.
   assign unused_addr = ^addr;

   assign accept = (state_q == StIdle) && (MemRead || MemWrite);
   assign finish = (state_q == StBusy) && (cnt_q == '0);

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (accept) state_d = StBusy;
         StBusy:  if (finish) state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output logic
   always_comb begin
      state = (state_q == StDone);
      rd    = rd_q;
   end

   // Word assembled from the latched aligned address, lowest byte first.
   always_comb begin
      rd_word = '0;
      for (int i = 0; i < NB; i++) begin
         rd_word[8*i +: 8] = mem_array[addr_q | IdxW'(i)];
      end
   end

   // Datapath next-state: operands are frozen at accept so later input changes
   // cannot disturb the access in flight.
   always_comb begin
      cnt_d  = cnt_q;
      addr_d = addr_q;
      wd_d   = wd_q;
      be_d   = be_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (accept) begin
         cnt_d  = CntW'(LATENCY - 1);
         addr_d = addr[IdxW-1:0] & AlignMask;
         wd_d   = wd;
         wr_d   = MemWrite;
`ifdef DMEM_BYTE_STROBE_EN
         be_d   = be;
`else
         be_d   = '1;
`endif
      end
      if (state_q == StBusy && cnt_q != '0) begin
         cnt_d = cnt_q - CntW'(1);
      end
      if (finish && !wr_q) begin
         rd_d = rd_word;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         addr_q <= '0;
         wd_q   <= '0;
         be_q   <= '0;
         wr_q   <= 1'b0;
         rd_q   <= '0;
      end else begin
         cnt_q  <= cnt_d;
         addr_q <= addr_d;
         wd_q   <= wd_d;
         be_q   <= be_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
      end
   end

   // Storage is not reset; a reset in BUSY suppresses the pending write.
   always_ff @(posedge clk) begin
      if (!rst && finish && wr_q) begin
         for (int i = 0; i < NB; i++) begin
            if (be_q[i]) begin
               mem_array[addr_q | IdxW'(i)] <= wd_q[8*i +: 8];
            end
         end
      end
   end

endmodule

// File: tb/tb_data_mem_wait.sv
module tb_data_mem_wait;

   logic        clk;
   logic        rst;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] wd;
   logic [31:0] addr;
`ifdef DMEM_BYTE_STROBE_EN
   logic [3:0]  be;
`endif
   logic [31:0] rd;
   logic        state;

   int n_cmp = 0;
   int n_err = 0;

   data_mem_wait #(
      .DATA_W (32),
      .ADDR_W (32),
      .DEPTH  (1024),
      .LATENCY(4)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .MemRead (MemRead),
      .MemWrite(MemWrite),
      .wd      (wd),
      .addr    (addr),
`ifdef DMEM_BYTE_STROBE_EN
      .be      (be),
`endif
      .rd      (rd),
      .state   (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one request, scramble the inputs after accept, and return the number
   // of edges from the accept edge to the first cycle with state high.
   task automatic do_op(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int lat);
      MemRead  = r;
      MemWrite = w;
      addr     = a;
      wd       = d;
      @(posedge clk); #1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      addr     = 32'h0000_03FC;
      wd       = 32'hCAFE_F00D;
      lat      = 1;
      while (!state && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // Completes an op: checks latency and that the pulse lasts one cycle.
   task automatic op(input string tag, input logic r, input logic w,
                     input logic [31:0] a, input logic [31:0] d);
      int lat;
      do_op(r, w, a, d, lat);
      check({tag, "_latency"}, lat, 5);
      @(posedge clk); #1;
      check({tag, "_pulse_width"}, {31'd0, state}, 32'd0);
   endtask

   initial begin
      int lat;
      int pulses;
      int p[3];
      rst      = 1'b1;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      wd       = '0;
      addr     = '0;
`ifdef DMEM_BYTE_STROBE_EN
      be       = 4'hF;
`endif
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", {31'd0, state}, 32'd0);
      check("reset_rd", rd, 32'd0);
      rst = 1'b0;

      // Basic write then read
      do_op(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, lat);
      check("wr10_latency", lat, 5);
      check("wr10_rd_unchanged", rd, 32'd0);
      @(posedge clk); #1;
      check("wr10_byte0", {24'd0, dut.mem_array[16]}, 32'h0000_00EF);
      check("wr10_byte3", {24'd0, dut.mem_array[19]}, 32'h0000_00DE);
      op("rd10", 1'b1, 1'b0, 32'h10, 32'h0);
      check("rd10_data", rd, 32'hDEAD_BEEF);

      // Alignment and wrap-around
      op("wr14", 1'b0, 1'b1, 32'h14, 32'h0BAD_F00D);
      op("rd14", 1'b1, 1'b0, 32'h14, 32'h0);
      check("rd14_data", rd, 32'h0BAD_F00D);
      op("rd13", 1'b1, 1'b0, 32'h13, 32'h0);
      check("rd13_aligned", rd, 32'hDEAD_BEEF);
      op("rd14b", 1'b1, 1'b0, 32'h14, 32'h0);
      check("rd14b_data", rd, 32'h0BAD_F00D);
      op("rd413", 1'b1, 1'b0, 32'h413, 32'h0);
      check("rd413_wrap", rd, 32'hDEAD_BEEF);

      // Simultaneous read and write: write wins, rd untouched
      op("both20", 1'b1, 1'b1, 32'h20, 32'h1234_5678);
      check("both20_rd_unchanged", rd, 32'hDEAD_BEEF);
      op("rd20", 1'b1, 1'b0, 32'h20, 32'h0);
      check("rd20_data", rd, 32'h1234_5678);

      // Reset during BUSY aborts a write
      op("wr30", 1'b0, 1'b1, 32'h30, 32'h5566_7788);
      MemWrite = 1'b1;
      addr     = 32'h30;
      wd       = 32'hAAAA_AAAA;
      @(posedge clk); #1;
      MemWrite = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst    = 1'b0;
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         if (state) pulses++;
         @(posedge clk); #1;
      end
      check("abort_no_pulse", pulses, 0);
      check("abort_rd_reset", rd, 32'd0);
      op("rd30", 1'b1, 1'b0, 32'h30, 32'h0);
      check("rd30_preserved", rd, 32'h5566_7788);

      // Requests ignored while rst is high
      rst      = 1'b1;
      MemWrite = 1'b1;
      addr     = 32'h30;
      wd       = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      MemWrite = 1'b0;
      rst      = 1'b0;
      pulses   = 0;
      for (int i = 0; i < 8; i++) begin
         if (state) pulses++;
         @(posedge clk); #1;
      end
      check("rst_req_no_pulse", pulses, 0);
      op("rd30b", 1'b1, 1'b0, 32'h30, 32'h0);
      check("rd30b_preserved", rd, 32'h5566_7788);

      // Held MemRead: back-to-back pulses every LATENCY+2 cycles
      MemRead = 1'b1;
      addr    = 32'h10;
      pulses  = 0;
      for (int c = 1; c <= 17; c++) begin
         @(posedge clk); #1;
         if (state) begin
            if (pulses < 3) p[pulses] = c;
            pulses++;
         end
      end
      MemRead = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("b2b_count", pulses, 3);
      check("b2b_first", p[0], 5);
      check("b2b_gap1", p[1] - p[0], 6);
      check("b2b_gap2", p[2] - p[1], 6);
      check("b2b_data", rd, 32'hDEAD_BEEF);

`ifdef DMEM_BYTE_STROBE_EN
      be = 4'hF;
      op("wr40", 1'b0, 1'b1, 32'h40, 32'hFFFF_FFFF);
      be = 4'b0101;
      op("wr40be", 1'b0, 1'b1, 32'h40, 32'h1122_3344);
      be = 4'hF;
      op("rd40", 1'b1, 1'b0, 32'h40, 32'h0);
      check("rd40_strobe", rd, 32'hFF22_FF44);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/data_mem_wait.md
DATA_MEM_WAIT -- requirements
Module: data_mem_wait

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data word width in bits, a multiple of 8.
REQ-002 SHALL have parameter ADDR_W, default 32: byte-address width.
REQ-003 SHALL have parameter DEPTH, default 1024: array size in bytes, a power of two and at least DATA_W/8.
REQ-004 SHALL have parameter LATENCY, default 4: cycles from request accept to completion, at least 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port MemRead, input, 1 bit: read request.
REQ-008 SHALL have port MemWrite, input, 1 bit: write request.
REQ-009 SHALL have port wd, input, DATA_W bits: write data.
REQ-010 SHALL have port addr, input, ADDR_W bits: byte address.
REQ-011 SHALL have port rd, output, DATA_W bits: read data.
REQ-012 SHALL have port state, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL hold storage as a byte array named mem_array[0:DEPTH-1], little-endian, so it can be preloaded with $readmemh.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY and DONE.
REQ-015 In IDLE with MemRead or MemWrite high, SHALL latch addr, wd and op, load counter with LATENCY-1, and go to BUSY.
REQ-016 In BUSY, SHALL decrement counter each cycle; at counter==0 it SHALL perform the access and go to DONE.
REQ-017 In DONE, SHALL assert state for exactly one cycle, then return to IDLE; total accept-to-state latency is LATENCY+1 cycles.
REQ-018 On a read, rd SHALL equal bytes [a+DATA_W/8-1 .. a] (a = latched aligned address), SHALL be valid in DONE, and SHALL hold until the next read completes.
REQ-019 On a write, the bytes SHALL be updated at the BUSY->DONE edge; rd SHALL be unchanged.
REQ-020 The address SHALL be aligned down to a DATA_W/8 boundary, then reduced modulo DEPTH (wrap-around, no error).
REQ-021 If MemRead and MemWrite are high together in IDLE, the write SHALL take priority and the read SHALL be dropped.
REQ-022 Requests in BUSY or DONE SHALL be ignored; input changes after accept SHALL not affect the operation in flight.
REQ-023 A request held high in DONE SHALL be accepted on the following IDLE cycle (back-to-back period LATENCY+2 cycles).

Reset
REQ-024 On rst high at a clock edge, the FSM SHALL go to IDLE, state SHALL be 0, rd SHALL be 0 and counter SHALL be 0.
REQ-025 Reset SHALL NOT clear mem_array.
REQ-026 Reset during BUSY SHALL abort the operation: a pending write SHALL NOT modify memory and no state pulse SHALL occur.
REQ-027 Requests SHALL be ignored while rst is high.

Configuration
REQ-028 With macro DMEM_BYTE_STROBE_EN defined, SHALL add input port be, DATA_W/8 bits, latched at accept; a write SHALL update only the bytes whose be bit is 1, with be[0] the lowest address.
REQ-029 Without DMEM_BYTE_STROBE_EN, port be SHALL not exist and every write SHALL update all DATA_W/8 bytes.

Verification
REQ-030 Reset, then write 0xDEADBEEF to addr 0x10 and read back (LATENCY=4) -> state at cycle 5 after each accept; rd=0xDEADBEEF; mem_array[0x10]=0xEF.
REQ-031 Read of addr 0x13 and of addr 0x413 (DEPTH=1024) -> both return the word at 0x10.
REQ-032 MemRead=MemWrite=1 with wd=0x12345678 at 0x20 -> word written; rd unchanged from previous value.
REQ-033 Write 0xAAAAAAAA to 0x30, with rst pulsed during BUSY -> no state pulse; a later read of 0x30 returns the prior preloaded value.
REQ-034 Hold MemRead high continuously for 3 reads -> state pulses spaced LATENCY+2=6 cycles apart; no request lost or duplicated.
REQ-035 With DMEM_BYTE_STROBE_EN, be=4'b0101 and wd=0x11223344 over 0xFFFFFFFF -> readback 0xFF22FF44.
